// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous DRAM between NCORES cores
// (round-robin, or fixed priority when MEM_ARB_FIXED_PRI_EN is defined) and the host port.
module mem_arbiter #(
    parameter int NCORES = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    localparam int IDW = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               status,
    input  logic [NCORES-1:0]        core_req,
    input  logic [NCORES-1:0]        core_wr_en,
    input  logic [NCORES*ADDR_W-1:0] core_addr,
    input  logic [NCORES*DATA_W-1:0] core_wdata,
    output logic [NCORES-1:0]        core_ack,
    output logic [DATA_W-1:0]        core_rdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     arb_busy,
    input  logic [ADDR_W-1:0]        com_addr,
    input  logic [DATA_W-1:0]        com_data_in,
    input  logic                     com_wr_en,
    output logic [DATA_W-1:0]        com_data_out,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wr_en,
    input  logic [DATA_W-1:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr_q, mem_wr_d;
    logic [NCORES-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mask_q, mask_d;

    logic                run;
    logic                host;
    logic [NCORES-1:0]   gnt_oh;
    logic [NCORES-1:0]   elig;
    logic                found;
    logic [IDW-1:0]      win;

    assign run    = (status == 2'd1);
    assign host   = !run && (state_q == S_IDLE);
    assign gnt_oh = {{(NCORES-1){1'b0}}, 1'b1} << grant_q;
    // The core acked last cycle sits out one arbitration round.
    assign elig   = core_req & ~(mask_q ? gnt_oh : '0);

`ifdef MEM_ARB_FIXED_PRI_EN
    // Lowest-index eligible core wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (!found && elig[k]) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW:0]   sum;

    // Search eligible cores starting at the round-robin pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NCORES; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NCORES)) begin
                sum = sum - (IDW+1)'(NCORES);
            end
            if (!found && elig[sum[IDW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    // Pointer moves past the winner only when its ack is issued.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_RESP) begin
            ptr_d = (grant_q == IDW'(NCORES-1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state logic: grant in IDLE, one DRAM cycle, then ack.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = 1'b0;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mask_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run && found) begin
                    grant_d     = win;
                    mem_addr_d  = core_addr[win*ADDR_W +: ADDR_W];
                    mem_wdata_d = core_wdata[win*DATA_W +: DATA_W];
                    mem_wr_d    = core_wr_en[win];
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                rdata_d = mem_rdata;
                ack_d   = gnt_oh;
                mask_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mask_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mask_q      <= mask_d;
        end
    end

    assign mem_addr     = host ? com_addr    : mem_addr_q;
    assign mem_wdata    = host ? com_data_in : mem_wdata_q;
    assign mem_wr_en    = host ? com_wr_en   : mem_wr_q;
    assign com_data_out = mem_rdata;
    assign core_ack     = ack_q;
    assign core_rdata   = rdata_q;
    assign grant_id     = grant_q;
    assign arb_busy     = (state_q != S_IDLE);

endmodule
